// File: rtl/tlb_seq_ctl_if.sv
// ---------------------------------------------------------------------------
// tlb_seq_ctl_if
//   Command/response and slice-facing bus of the 2-way translation buffer
//   sequencer.
//
//   Handshake: a command transfers on a rising b_clk_l edge where
//   cmd_valid_h=1 and busy_h=0. The requester holds cmd_h/va_h stable until
//   that edge. cmd_valid_h offered while busy_h=1 is ignored, not queued.
//   rsp_valid_h is a one-cycle pulse with no back-pressure. The other rsp_*
//   fields hold their last values.
//
//   Signals
//     cmd_valid_h, cmd_h[1:0], va_h[TAG_W+IDX_W-1:0]   requester -> sequencer
//     hit_h[1:0], tag_perr_h[1:0]                      slices    -> sequencer
//     busy_h, rsp_valid_h, rsp_hit_h, rsp_grp_h, rsp_perr_h
//                                                      sequencer -> requester
//     index_h, tag_h, valid_h, tag_par_h, write_h[1:0] sequencer -> slices
// ---------------------------------------------------------------------------
interface tlb_seq_ctl_if #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 15
);
  logic                   cmd_valid_h;
  logic [1:0]             cmd_h;
  logic [TAG_W+IDX_W-1:0] va_h;
  logic [1:0]             hit_h;
  logic [1:0]             tag_perr_h;

  logic                   busy_h;
  logic [IDX_W-1:0]       index_h;
  logic [TAG_W-1:0]       tag_h;
  logic                   valid_h;
  logic                   tag_par_h;
  logic [1:0]             write_h;
  logic                   rsp_valid_h;
  logic                   rsp_hit_h;
  logic                   rsp_grp_h;
  logic                   rsp_perr_h;

  // Requester / slice side (drives commands and hit information).
  modport master (
    output cmd_valid_h, cmd_h, va_h, hit_h, tag_perr_h,
    input  busy_h, index_h, tag_h, valid_h, tag_par_h, write_h,
    input  rsp_valid_h, rsp_hit_h, rsp_grp_h, rsp_perr_h
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid_h, cmd_h, va_h, hit_h, tag_perr_h,
    output busy_h, index_h, tag_h, valid_h, tag_par_h, write_h,
    output rsp_valid_h, rsp_hit_h, rsp_grp_h, rsp_perr_h
  );
endinterface

// File: rtl/tlb_seq_ctl.sv
// ---------------------------------------------------------------------------
// tlb_seq_ctl
//   Sequencer for a 2-way translation buffer made of two slices (group 0/1).
//   It runs PROBE, FILL, TBIS (single invalidate) and TBIA (invalidate all)
//   commands. It drives the shared index/tag/valid/tag-parity buses and the
//   per-group write strobes, and keeps one replacement bit per set.
//
//   Ports
//     b_clk_l    in   bus clock, rising-edge registers
//     reset_l    in   asynchronous active-low reset
//     bus        slave modport of tlb_seq_ctl_if (commands, slice bus, rsp)
//     dbg_state  out  current FSM state encoding
//
//   All outputs are registered. The write strobe is asserted for exactly one
//   full cycle. Index, tag, valid and parity are stable for that whole cycle.
// ---------------------------------------------------------------------------
module tlb_seq_ctl #(
  parameter int SETS  = 256,
  parameter int TAG_W = 15
) (
  input  logic                b_clk_l,
  input  logic                reset_l,
  tlb_seq_ctl_if.slave        bus,
  output logic [2:0]          dbg_state
);
  localparam int IDX_W = $clog2(SETS);

  localparam logic [1:0] CMD_PROBE = 2'b00;
  localparam logic [1:0] CMD_FILL  = 2'b01;
  localparam logic [1:0] CMD_TBIS  = 2'b10;
  localparam logic [1:0] CMD_TBIA  = 2'b11;

  // INIT is a single arming cycle after reset. The set-clearing walk itself
  // runs in WALK for both INIT and TBIA. walk_rsp_q tells them apart.
  typedef enum logic [2:0] {
    S_INIT, S_WALK, S_IDLE, S_PRB, S_FPRB, S_FWR, S_SPRB, S_SWR
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               valid_q, valid_d;
  logic               par_q;
  logic [1:0]         write_q, write_d;
  logic               busy_q, busy_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic               rsp_grp_q, rsp_grp_d;
  logic               rsp_perr_q, rsp_perr_d;
  logic               walk_rsp_q, walk_rsp_d;
  logic               tgt_q, tgt_d;
  logic               perr_q, perr_d;
  logic [SETS-1:0]    repl_q;
  logic               repl_we;
  logic               repl_wbit;

  // Probe qualification from the slices' combinational hit information.
  logic [1:0] clean;
  logic       multi;
  logic       perr_any;
  logic       single;
  logic       fill_tgt;

  assign clean    = bus.hit_h & ~bus.tag_perr_h;
  assign multi    = &bus.hit_h;
  assign perr_any = (|bus.tag_perr_h) | multi;
  assign single   = (^clean) & ~multi;

  // Fill target: the clean hit, else scrub the lowest parity-bad way,
  // else the way the replacement bit names.
  always_comb begin
    fill_tgt = repl_q[index_q];
    if (single)
      fill_tgt = clean[1];
    else if (|bus.tag_perr_h)
      fill_tgt = ~bus.tag_perr_h[0];
  end

  always_ff @(posedge b_clk_l or negedge reset_l) begin
    if (!reset_l) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    write_d     = 2'b00;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = rsp_hit_q;
    rsp_grp_d   = rsp_grp_q;
    rsp_perr_d  = rsp_perr_q;
    walk_rsp_d  = walk_rsp_q;
    tgt_d       = tgt_q;
    perr_d      = perr_q;
    repl_we     = 1'b0;
    repl_wbit   = 1'b0;

    case (state_q)
      S_INIT: begin
        state_d    = S_WALK;
        index_d    = '0;
        tag_d      = '0;
        valid_d    = 1'b0;
        write_d    = 2'b11;
        busy_d     = 1'b1;
        walk_rsp_d = 1'b0;
      end

      S_WALK: begin
        repl_we   = 1'b1;
        repl_wbit = 1'b0;
        if (index_q == IDX_W'(SETS - 1)) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          rsp_valid_d = walk_rsp_q;
        end else begin
          index_d = index_q + IDX_W'(1);
          write_d = 2'b11;
        end
      end

      S_IDLE: begin
        if (bus.cmd_valid_h) begin
          busy_d  = 1'b1;
          index_d = bus.va_h[IDX_W-1:0];
          tag_d   = bus.va_h[TAG_W+IDX_W-1:IDX_W];
          valid_d = (bus.cmd_h == CMD_FILL);
          case (bus.cmd_h)
            CMD_PROBE: state_d = S_PRB;
            CMD_FILL:  state_d = S_FPRB;
            CMD_TBIS:  state_d = S_SPRB;
            CMD_TBIA: begin
              state_d    = S_WALK;
              index_d    = '0;
              tag_d      = '0;
              write_d    = 2'b11;
              walk_rsp_d = 1'b1;
            end
            default:   state_d = S_IDLE;
          endcase
        end
      end

      S_PRB: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_hit_d   = single;
        rsp_grp_d   = clean[1];
        rsp_perr_d  = perr_any;
        // A clean single hit makes the other way the next victim.
        if (single) begin
          repl_we   = 1'b1;
          repl_wbit = ~clean[1];
        end
      end

      S_FPRB: begin
        state_d = S_FWR;
        tgt_d   = fill_tgt;
        perr_d  = perr_any;
        write_d = fill_tgt ? 2'b10 : 2'b01;
      end

      S_FWR: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_grp_d   = tgt_q;
        rsp_perr_d  = perr_q;
        repl_we     = 1'b1;
        repl_wbit   = ~tgt_q;
      end

      S_SPRB: begin
        if (|bus.hit_h) begin
          // On a multi-hit both ways are invalidated together.
          state_d = S_SWR;
          write_d = bus.hit_h;
        end else begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end

      S_SWR: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        rsp_valid_d = 1'b1;
      end

      default: begin
        state_d = S_INIT;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge b_clk_l or negedge reset_l) begin
    if (!reset_l) begin
      index_q     <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      par_q       <= 1'b0;
      write_q     <= 2'b00;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_grp_q   <= 1'b0;
      rsp_perr_q  <= 1'b0;
      walk_rsp_q  <= 1'b0;
      tgt_q       <= 1'b0;
      perr_q      <= 1'b0;
      repl_q      <= '0;
    end else begin
      index_q     <= index_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      // Odd parity over {par, valid, tag}, registered alongside the tag.
      par_q       <= ~^{valid_d, tag_d};
      write_q     <= write_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_grp_q   <= rsp_grp_d;
      rsp_perr_q  <= rsp_perr_d;
      walk_rsp_q  <= walk_rsp_d;
      tgt_q       <= tgt_d;
      perr_q      <= perr_d;
      if (repl_we)
        repl_q[index_q] <= repl_wbit;
    end
  end

  assign bus.busy_h      = busy_q;
  assign bus.index_h     = index_q;
  assign bus.tag_h       = tag_q;
  assign bus.valid_h     = valid_q;
  assign bus.tag_par_h   = par_q;
  assign bus.write_h     = write_q;
  assign bus.rsp_valid_h = rsp_valid_q;
  assign bus.rsp_hit_h   = rsp_hit_q;
  assign bus.rsp_grp_h   = rsp_grp_q;
  assign bus.rsp_perr_h  = rsp_perr_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_tlb_seq_ctl.sv
// ---------------------------------------------------------------------------
// tb_tlb_seq_ctl
//   Self-checking bench for tlb_seq_ctl. Expected slice writes go through a
//   scoreboard queue. The reference model tracks per-set replacement bits and
//   the held response fields directly from the command rules.
// ---------------------------------------------------------------------------
module tb_tlb_seq_ctl;
  localparam logic [1:0] C_PRB  = 2'b00;
  localparam logic [1:0] C_FILL = 2'b01;
  localparam logic [1:0] C_TBIS = 2'b10;
  localparam logic [1:0] C_TBIA = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  tlb_seq_ctl_if bus ();

  tlb_seq_ctl dut (
    .b_clk_l   (clk),
    .reset_l   (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int checks;
  int errors;

  // {strobe[1:0], index[7:0], tag[14:0], valid, par}
  logic [26:0] exp_q[$];

  logic repl_m [256];
  logic m_hit, m_grp, m_perr;
  int   m_busy;

  int          obs_busy;
  int          obs_writes;
  logic        obs_rsp;
  logic [26:0] obs_first_wr;

  function automatic logic [26:0] wr_rec(input logic [1:0] s, input logic [7:0] i,
                                         input logic [14:0] t, input logic v);
    logic p;
    p = 1'b1 ^ v ^ (^t);  // odd parity: par ^ valid ^ tag bits == 1
    return {s, i, t, v, p};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) repl_m[i] = 1'b0;
    m_hit  = 1'b0;
    m_grp  = 1'b0;
    m_perr = 1'b0;
    m_busy = 0;
    exp_q.delete();
  endfunction

  function automatic void model_cmd(input logic [1:0] c, input logic [22:0] va,
                                    input logic [1:0] hit, input logic [1:0] perr);
    logic [7:0]  idx;
    logic [14:0] tg;
    logic [1:0]  cln;
    logic        both, one_clean, bad, tgt;
    idx       = va[7:0];
    tg        = va[22:8];
    cln       = hit & ~perr;
    both      = (hit == 2'b11);
    one_clean = ($countones(cln) == 1) && !both;
    bad       = (perr != 2'b00) || both;
    case (c)
      C_PRB: begin
        m_busy = 1;
        m_hit  = one_clean;
        m_grp  = cln[1];
        m_perr = bad;
        if (one_clean) repl_m[idx] = !cln[1];
      end
      C_FILL: begin
        if (one_clean)              tgt = cln[1];
        else if (perr != 2'b00)     tgt = perr[0] ? 1'b0 : 1'b1;
        else                        tgt = repl_m[idx];
        exp_q.push_back(wr_rec(tgt ? 2'b10 : 2'b01, idx, tg, 1'b1));
        repl_m[idx] = !tgt;
        m_busy = 2;
        m_grp  = tgt;
        m_perr = bad;
      end
      C_TBIS: begin
        if (hit != 2'b00) begin
          exp_q.push_back(wr_rec(hit, idx, tg, 1'b0));
          m_busy = 2;
        end else begin
          m_busy = 1;
        end
      end
      default: begin
        for (int i = 0; i < 256; i++) begin
          exp_q.push_back(wr_rec(2'b11, 8'(i), 15'h0, 1'b0));
          repl_m[i] = 1'b0;
        end
        m_busy = 256;
      end
    endcase
  endfunction

  // ---------------- driver / monitor ----------------
  task automatic wait_idle();
    int guard;
    guard = 0;
    while (bus.busy_h !== 1'b0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (bus.busy_h !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy_h=%b, expected 0 within 400 cycles", bus.busy_h);
    end
  endtask

  // Offers one command at a negedge, then watches each cycle until the
  // response pulse, comparing every write cycle against the scoreboard.
  task automatic issue(input logic [1:0] c, input logic [22:0] va,
                       input logic [1:0] hit, input logic [1:0] perr);
    int          guard;
    logic [26:0] got, exp;
    obs_busy     = 0;
    obs_writes   = 0;
    obs_rsp      = 1'b0;
    obs_first_wr = '0;
    wait_idle();
    bus.cmd_valid_h = 1'b1;
    bus.cmd_h       = c;
    bus.va_h        = va;
    bus.hit_h       = hit;
    bus.tag_perr_h  = perr;
    @(negedge clk);
    bus.cmd_valid_h = 1'b0;
    guard = 0;
    while (!obs_rsp && guard < 400) begin
      if (bus.busy_h === 1'b1) obs_busy++;
      if (bus.write_h !== 2'b00) begin
        got = {bus.write_h, bus.index_h, bus.tag_h, bus.valid_h, bus.tag_par_h};
        if (obs_writes == 0) obs_first_wr = got;
        obs_writes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_write: got %h, expected no write", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL sb_write: got %h, expected %h", got, exp);
          end
        end
      end
      if (bus.rsp_valid_h === 1'b1) obs_rsp = 1'b1;
      else begin
        @(negedge clk);
        guard++;
      end
    end
    checks++;
    if (!obs_rsp) begin
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid_h, expected pulse (cmd=%0d)", c);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
    bus.hit_h      = 2'b00;
    bus.tag_perr_h = 2'b00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n           = 1'b0;
    bus.cmd_valid_h = 1'b0;
    bus.cmd_h       = 2'b00;
    bus.va_h        = '0;
    bus.hit_h       = 2'b00;
    bus.tag_perr_h  = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy_h !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b, expected 1", bus.busy_h);
    end
    checks++;
    if ({bus.write_h, bus.valid_h, bus.tag_par_h, bus.rsp_valid_h,
         bus.rsp_hit_h, bus.rsp_grp_h, bus.rsp_perr_h} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outs: got wr=%b v=%b p=%b rsp=%b%b%b%b, expected all 0",
               bus.write_h, bus.valid_h, bus.tag_par_h, bus.rsp_valid_h,
               bus.rsp_hit_h, bus.rsp_grp_h, bus.rsp_perr_h);
    end
    checks++;
    if (bus.index_h !== 8'h00 || bus.tag_h !== 15'h0) begin
      errors++; $display("FAIL reset_bus: got idx=%h tag=%h, expected 0/0", bus.index_h, bus.tag_h);
    end
  endtask

  task automatic test_init_walk();
    int   busy_n, wr_n;
    logic rsp_seen;
    busy_n   = 0;
    wr_n     = 0;
    rsp_seen = 1'b0;
    rst_n    = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_h === 1'b1) rsp_seen = 1'b1;
      if (bus.busy_h !== 1'b1) break;
      busy_n++;
      if (bus.write_h === 2'b11) begin
        checks++;
        if (bus.index_h !== 8'(wr_n) || bus.valid_h !== 1'b0 ||
            bus.tag_h !== 15'h0 || bus.tag_par_h !== 1'b1) begin
          errors++;
          $display("FAIL init_walk: got idx=%h v=%b tag=%h p=%b, expected idx=%h v=0 tag=0 p=1",
                   bus.index_h, bus.valid_h, bus.tag_h, bus.tag_par_h, 8'(wr_n));
        end
        wr_n++;
      end
    end
    checks++;
    if (busy_n != 256) begin
      errors++; $display("FAIL init_busy_len: got %0d, expected 256", busy_n);
    end
    checks++;
    if (wr_n != 256) begin
      errors++; $display("FAIL init_write_cnt: got %0d, expected 256", wr_n);
    end
    checks++;
    if (rsp_seen !== 1'b0 || bus.write_h !== 2'b00) begin
      errors++;
      $display("FAIL init_exit: got rsp_seen=%b write=%b, expected 0/00", rsp_seen, bus.write_h);
    end
  endtask

  task automatic test_fill();
    logic [22:0] va;
    logic [14:0] tg;
    tg = 15'h0012;
    va = {tg, 8'h1A};
    model_cmd(C_FILL, va, 2'b00, 2'b00);
    issue(C_FILL, va, 2'b00, 2'b00);
    checks++;
    if (obs_first_wr[26:17] !== {2'b01, 8'h1A} || obs_first_wr[0] !== ~^{1'b1, tg}) begin
      errors++;
      $display("FAIL fill_first: got wr=%b idx=%h p=%b, expected 01 1a %b",
               obs_first_wr[26:25], obs_first_wr[24:17], obs_first_wr[0], ~^{1'b1, tg});
    end
    checks++;
    if (bus.rsp_grp_h !== 1'b0 || bus.rsp_perr_h !== 1'b0 || obs_busy != 2) begin
      errors++;
      $display("FAIL fill_rsp: got grp=%b perr=%b busy=%0d, expected 0 0 2",
               bus.rsp_grp_h, bus.rsp_perr_h, obs_busy);
    end
    va = {15'h0034, 8'h1A};
    model_cmd(C_FILL, va, 2'b00, 2'b00);
    issue(C_FILL, va, 2'b00, 2'b00);
    checks++;
    if (obs_first_wr[26:25] !== 2'b10 || bus.rsp_grp_h !== 1'b1) begin
      errors++;
      $display("FAIL fill_second: got wr=%b grp=%b, expected 10 1", obs_first_wr[26:25], bus.rsp_grp_h);
    end
  endtask

  task automatic test_probe();
    logic [22:0] va;
    va = {15'h0034, 8'h1A};
    model_cmd(C_PRB, va, 2'b10, 2'b00);
    issue(C_PRB, va, 2'b10, 2'b00);
    checks++;
    if (bus.rsp_hit_h !== 1'b1 || bus.rsp_grp_h !== 1'b1 || bus.rsp_perr_h !== 1'b0 ||
        obs_busy != 1 || obs_writes != 0) begin
      errors++;
      $display("FAIL probe_hit: got hit=%b grp=%b perr=%b busy=%0d wr=%0d, expected 1 1 0 1 0",
               bus.rsp_hit_h, bus.rsp_grp_h, bus.rsp_perr_h, obs_busy, obs_writes);
    end
    va = {15'h0056, 8'h1A};
    model_cmd(C_FILL, va, 2'b00, 2'b00);
    issue(C_FILL, va, 2'b00, 2'b00);
    checks++;
    if (obs_first_wr[26:25] !== 2'b01 || bus.rsp_grp_h !== 1'b0) begin
      errors++;
      $display("FAIL probe_victim: got wr=%b grp=%b, expected 01 0", obs_first_wr[26:25], bus.rsp_grp_h);
    end
  endtask

  task automatic test_multi_hit();
    logic [22:0] va;
    va = {15'h0101, 8'h20};
    model_cmd(C_PRB, va, 2'b11, 2'b00);
    issue(C_PRB, va, 2'b11, 2'b00);
    checks++;
    if (bus.rsp_hit_h !== 1'b0 || bus.rsp_perr_h !== 1'b1) begin
      errors++;
      $display("FAIL multi_probe: got hit=%b perr=%b, expected 0 1", bus.rsp_hit_h, bus.rsp_perr_h);
    end
    model_cmd(C_TBIS, va, 2'b11, 2'b00);
    issue(C_TBIS, va, 2'b11, 2'b00);
    checks++;
    if (obs_first_wr[26:25] !== 2'b11 || obs_first_wr[1] !== 1'b0 ||
        obs_writes != 1 || obs_busy != 2) begin
      errors++;
      $display("FAIL multi_tbis: got wr=%b v=%b n=%0d busy=%0d, expected 11 0 1 2",
               obs_first_wr[26:25], obs_first_wr[1], obs_writes, obs_busy);
    end
    model_cmd(C_TBIS, va, 2'b00, 2'b00);
    issue(C_TBIS, va, 2'b00, 2'b00);
    checks++;
    if (obs_writes != 0 || obs_busy != 1) begin
      errors++;
      $display("FAIL tbis_miss: got wr=%0d busy=%0d, expected 0 1", obs_writes, obs_busy);
    end
  endtask

  task automatic test_scrub();
    logic [22:0] va;
    va = {15'h0777, 8'h33};
    model_cmd(C_FILL, va, 2'b00, 2'b10);
    issue(C_FILL, va, 2'b00, 2'b10);
    checks++;
    if (obs_first_wr[26:25] !== 2'b10 || bus.rsp_grp_h !== 1'b1 || bus.rsp_perr_h !== 1'b1) begin
      errors++;
      $display("FAIL scrub: got wr=%b grp=%b perr=%b, expected 10 1 1",
               obs_first_wr[26:25], bus.rsp_grp_h, bus.rsp_perr_h);
    end
  endtask

  task automatic test_busy_ignore();
    logic [22:0] vax;
    logic [26:0] got, exp;
    int          guard, wr_n;
    vax = {15'h1234, 8'h77};
    wait_idle();
    model_cmd(C_TBIA, 23'h0, 2'b00, 2'b00);
    bus.cmd_valid_h = 1'b1;
    bus.cmd_h       = C_TBIA;
    bus.va_h        = 23'h0;
    @(negedge clk);
    // Hold a PROBE for the whole walk; it must wait for busy_h=0.
    bus.cmd_h = C_PRB;
    bus.va_h  = vax;
    guard = 0;
    wr_n  = 0;
    while (bus.busy_h === 1'b1 && guard < 400) begin
      if (bus.write_h !== 2'b00) begin
        got = {bus.write_h, bus.index_h, bus.tag_h, bus.valid_h, bus.tag_par_h};
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 27'h0;
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL tbia_walk: got %h, expected %h", got, exp);
        end
        wr_n++;
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (wr_n != 256 || bus.rsp_valid_h !== 1'b1) begin
      errors++;
      $display("FAIL tbia_end: got writes=%0d rsp=%b, expected 256 1", wr_n, bus.rsp_valid_h);
    end
    exp_q.delete();
    @(negedge clk);
    bus.cmd_valid_h = 1'b0;
    checks++;
    if (bus.busy_h !== 1'b1 || bus.index_h !== vax[7:0] || bus.write_h !== 2'b00) begin
      errors++;
      $display("FAIL held_accept: got busy=%b idx=%h wr=%b, expected 1 %h 00",
               bus.busy_h, bus.index_h, bus.write_h, vax[7:0]);
    end
    model_cmd(C_PRB, vax, 2'b00, 2'b00);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid_h !== 1'b1 || bus.rsp_hit_h !== m_hit || bus.rsp_perr_h !== m_perr) begin
      errors++;
      $display("FAIL held_rsp: got v=%b hit=%b perr=%b, expected 1 %b %b",
               bus.rsp_valid_h, bus.rsp_hit_h, bus.rsp_perr_h, m_hit, m_perr);
    end
    @(negedge clk);
    checks++;
    if (bus.busy_h !== 1'b0) begin
      errors++; $display("FAIL held_once: got busy=%b, expected 0", bus.busy_h);
    end
  endtask

  task automatic test_random();
    logic [7:0]  idx_tab [4];
    logic [1:0]  c, hit, perr;
    logic [22:0] va;
    int          n_tbia;
    idx_tab[0] = 8'h1A; idx_tab[1] = 8'h40; idx_tab[2] = 8'h41; idx_tab[3] = 8'hFF;
    n_tbia = 0;
    for (int n = 0; n < 60; n++) begin
      c = 2'($urandom_range(0, 3));
      if (c == C_TBIA) begin
        if (n_tbia >= 1) c = C_FILL;
        else n_tbia++;
      end
      va   = {15'($urandom_range(0, 32767)), idx_tab[$urandom_range(0, 3)]};
      hit  = 2'($urandom_range(0, 3));
      perr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      model_cmd(c, va, hit, perr);
      issue(c, va, hit, perr);
      checks++;
      if (obs_busy != m_busy) begin
        errors++; $display("FAIL rnd_busy: got %0d, expected %0d (cmd=%0d)", obs_busy, m_busy, c);
      end
      checks++;
      if (bus.rsp_hit_h !== m_hit || bus.rsp_grp_h !== m_grp || bus.rsp_perr_h !== m_perr) begin
        errors++;
        $display("FAIL rnd_rsp: got hit=%b grp=%b perr=%b, expected %b %b %b (cmd=%0d hit=%b perr=%b)",
                 bus.rsp_hit_h, bus.rsp_grp_h, bus.rsp_perr_h, m_hit, m_grp, m_perr, c, hit, perr);
      end
    end
  endtask

  task automatic test_reset_in_fwr();
    logic [22:0] va;
    va = {15'h0ABC, 8'h5C};
    wait_idle();
    bus.cmd_valid_h = 1'b1;
    bus.cmd_h       = C_FILL;
    bus.va_h        = va;
    @(negedge clk);
    bus.cmd_valid_h = 1'b0;
    @(negedge clk);
    checks++;
    if ($countones(bus.write_h) != 1 || bus.index_h !== 8'h5C) begin
      errors++;
      $display("FAIL fwr_reach: got wr=%b idx=%h, expected one-hot 5c", bus.write_h, bus.index_h);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.write_h !== 2'b00 || bus.busy_h !== 1'b1 || bus.rsp_valid_h !== 1'b0) begin
      errors++;
      $display("FAIL fwr_reset: got wr=%b busy=%b rsp=%b, expected 00 1 0",
               bus.write_h, bus.busy_h, bus.rsp_valid_h);
    end
    model_reset();
    repeat (2) @(negedge clk);
    test_init_walk();
    model_cmd(C_FILL, va, 2'b00, 2'b00);
    issue(C_FILL, va, 2'b00, 2'b00);
    checks++;
    if (bus.rsp_grp_h !== 1'b0 || obs_first_wr[26:25] !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_fill: got grp=%b wr=%b, expected 0 01", bus.rsp_grp_h, obs_first_wr[26:25]);
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] va;
    va = {15'h0F0F, 8'h41};
    model_cmd(C_FILL, va, 2'b00, 2'b00);
    issue(C_FILL, va, 2'b00, 2'b00);
    // Issued straight from the rsp cycle: accepted at the edge ending it.
    model_cmd(C_PRB, va, 2'b01, 2'b00);
    issue(C_PRB, va, 2'b01, 2'b00);
    checks++;
    if (bus.rsp_hit_h !== 1'b1 || bus.rsp_grp_h !== 1'b0 || obs_busy != 1) begin
      errors++;
      $display("FAIL b2b_probe: got hit=%b grp=%b busy=%0d, expected 1 0 1",
               bus.rsp_hit_h, bus.rsp_grp_h, obs_busy);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_init_walk();
    test_fill();
    test_probe();
    test_multi_hit();
    test_scrub();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    test_reset_in_fwr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
